// File: rtl/vga_scan_ctrl.sv
// vga_scan_ctrl -- VGA raster scan controller with line-buffer fetch handshake.
//
// Divides the system clock down to a pixel strobe and walks a horizontal and
// a vertical counter through the configured timing. It produces registered
// active-low syncs and a display-enable, and asks an external line buffer to
// load each visible line ahead of time. A fetch that is still outstanding
// when its line starts is dropped and recorded in a sticky underrun flag.
//
// Ports:
//   clk         in   system clock (PLL output), sole clock
//   rst         in   asynchronous active-high reset
//   en          in   run request; dropping it lets the current frame finish
//   lock        in   PLL lock; low forces IDLE on the next edge
//   fetch_ack   in   line-buffer load done (pulse or level)
//   pix_tick    out  one-clock pixel strobe
//   hsync       out  active-low horizontal sync
//   vsync       out  active-low vertical sync
//   de          out  active-video flag
//   x, y        out  current pixel / line counters (0 in IDLE)
//   frame_start out  one-clock pulse after the counters wrap to (0,0)
//   fetch_req   out  line-fetch request, held until acknowledged or dropped
//   fetch_line  out  line index being requested
//   underrun    out  sticky missed-fetch flag, cleared on IDLE->RUN
//   busy        out  controller is in RUN
module vga_scan_ctrl #(
    parameter int PIX_DIV  = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        lock,
    input  logic        fetch_ack,
    output logic        pix_tick,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        frame_start,
    output logic        fetch_req,
    output logic [10:0] fetch_line,
    output logic        underrun,
    output logic        busy
);

    localparam logic [10:0] HA       = 11'(H_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] VA       = 11'(V_ACTIVE);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] DIV_LAST = 16'(PIX_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]  state;
    logic [15:0] div;
    logic [10:0] hcnt;
    logic [10:0] vcnt;

    logic        h_wrap;
    logic        v_wrap;
    logic [10:0] h_nx;
    logic [10:0] v_nx;
    logic [10:0] ny;
    logic        issue;
    logic        deadline;
    logic        stop;

    function automatic logic hs_dec(input logic [10:0] h);
        return !((h >= HS_START) && (h < HS_END));
    endfunction

    function automatic logic vs_dec(input logic [10:0] v);
        return !((v >= VS_START) && (v < VS_END));
    endfunction

    function automatic logic de_dec(input logic [10:0] h, input logic [10:0] v);
        return (h < HA) && (v < VA);
    endfunction

    assign busy     = (state == RUN);
    assign pix_tick = busy && (div == DIV_LAST);
    assign x        = hcnt;
    assign y        = vcnt;

    // Next counter values; the sync/de registers decode these so they
    // change on the same edge as the counters themselves.
    always_comb begin
        h_wrap = (hcnt == H_LAST);
        v_wrap = (vcnt == V_LAST);
        h_nx   = hcnt;
        v_nx   = vcnt;
        if (pix_tick) begin
            h_nx = h_wrap ? 11'd0 : hcnt + 11'd1;
            if (h_wrap) begin
                v_nx = v_wrap ? 11'd0 : vcnt + 11'd1;
            end
        end
        // Line that follows the current one; it is the target of a fetch
        // issued when the current line enters its blanking.
        ny       = v_wrap ? 11'd0 : vcnt + 11'd1;
        issue    = pix_tick && (h_nx == HA) && (ny < VA);
        // A visible line is starting: any fetch still open is too late.
        deadline = pix_tick && h_wrap && (v_nx < VA);
        // en only takes effect at the very last pixel of a frame.
        stop     = pix_tick && h_wrap && v_wrap && !en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            div         <= '0;
            hcnt        <= '0;
            vcnt        <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            de          <= 1'b0;
            frame_start <= 1'b0;
            fetch_req   <= 1'b0;
            fetch_line  <= '0;
            underrun    <= 1'b0;
        end else if (state == IDLE) begin
            if (en && lock) begin
                // Start at the blanking of the last line so the first
                // line can be fetched before the frame begins.
                state       <= RUN;
                div         <= '0;
                hcnt        <= HA;
                vcnt        <= V_LAST;
                hsync       <= hs_dec(HA);
                vsync       <= vs_dec(V_LAST);
                de          <= de_dec(HA, V_LAST);
                frame_start <= 1'b0;
                underrun    <= 1'b0;
                fetch_req   <= 1'b1;
                fetch_line  <= '0;
            end
        end else begin
            if (!lock || stop) begin
                // Leaving RUN abandons any open fetch without flagging it.
                state       <= IDLE;
                div         <= '0;
                hcnt        <= '0;
                vcnt        <= '0;
                hsync       <= 1'b1;
                vsync       <= 1'b1;
                de          <= 1'b0;
                frame_start <= 1'b0;
                fetch_req   <= 1'b0;
            end else begin
                div         <= pix_tick ? 16'd0 : div + 16'd1;
                hcnt        <= h_nx;
                vcnt        <= v_nx;
                hsync       <= hs_dec(h_nx);
                vsync       <= vs_dec(v_nx);
                de          <= de_dec(h_nx, v_nx);
                frame_start <= pix_tick && h_wrap && v_wrap;
                // An ack on the deadline edge still counts as on time.
                if (fetch_req && fetch_ack) begin
                    fetch_req <= 1'b0;
                end else if (fetch_req && deadline) begin
                    fetch_req <= 1'b0;
                    underrun  <= 1'b1;
                end
                if (issue) begin
                    fetch_req  <= 1'b1;
                    fetch_line <= ny;
                end
            end
        end
    end

endmodule

// File: doc/vga_scan_ctrl.md
VGA_SCAN_CTRL -- requirements
Module: vga_scan_ctrl

Interface
REQ-001 Param PIX_DIV, default 10: system clocks per pixel; 252 MHz / 10 gives 25.2 MHz.
REQ-002 Params H_ACTIVE/H_FP/H_SYNC/H_BP, defaults 640/16/96/48: horizontal timing in pixels; H_TOTAL is their sum (800).
REQ-003 Params V_ACTIVE/V_FP/V_SYNC/V_BP, defaults 480/10/2/33: vertical timing in lines; V_TOTAL is their sum (525).
REQ-004 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-005 clk  in  1  system clock (PLL output), sole clock.
REQ-006 rst  in  1  async active-high reset.
REQ-007 en  in  1  run request.
REQ-008 lock  in  1  PLL lock; 0 forces IDLE.
REQ-009 fetch_ack  in  1  line-buffer load done, 1-clk pulse or level.
REQ-010 pix_tick  out  1  1-clk pixel strobe.
REQ-011 hsync, vsync  out  1 each  active-low syncs.
REQ-012 de  out  1  active-video flag.
REQ-013 x, y  out  11 each  current pixel and line counters.
REQ-014 frame_start  out  1  1-clk pulse at frame wrap.
REQ-015 fetch_req  out  1  line-fetch request.
REQ-016 fetch_line  out  11  line index requested.
REQ-017 underrun  out  1  sticky missed-fetch flag.
REQ-018 busy  out  1  FSM is in RUN.

Function
REQ-019 The FSM SHALL have 2 states: IDLE and RUN.
REQ-020 IDLE->RUN: when en=1 and lock=1 are sampled. On this edge: divider=0, hcnt=H_ACTIVE, vcnt=V_TOTAL-1, underrun cleared, fetch_req=1, fetch_line=0.
REQ-021 RUN->IDLE: immediately when lock=0 is sampled. Also on the pix_tick edge where hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1 if en=0.
REQ-022 In IDLE the outputs SHALL be: hsync=1, vsync=1, de=0, x=0, y=0, pix_tick=0, fetch_req=0, frame_start=0, busy=0. underrun SHALL hold its value.
REQ-023 Divider: counts 0..PIX_DIV-1 and wraps in RUN. pix_tick SHALL be 1 exactly when the divider equals PIX_DIV-1.
REQ-024 On each clk edge with pix_tick=1: hcnt increments. At H_TOTAL-1 it wraps to 0 and vcnt increments; vcnt wraps to 0 after V_TOTAL-1. No counter moves on other edges.
REQ-025 hsync, vsync and de SHALL be registered decodes of the next counter values, so they change on the same edge as the counters.
REQ-026 hsync=0 SHALL hold iff H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC.
REQ-027 vsync=0 SHALL hold iff V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC.
REQ-028 de=1 SHALL hold iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-029 x SHALL equal hcnt and y SHALL equal vcnt while in RUN.
REQ-030 frame_start SHALL be 1 for the single clk following the edge where the counters become (0,0).
REQ-031 Fetch issue: on a pix_tick edge where the next hcnt equals H_ACTIVE, compute ny = (vcnt==V_TOTAL-1) ? 0 : vcnt+1. If ny<V_ACTIVE, set fetch_req=1 and fetch_line=ny.
REQ-032 fetch_req SHALL stay high until fetch_ack=1 is sampled and clear on that edge. fetch_line SHALL stay stable while fetch_req=1.
REQ-033 Deadline: if fetch_req is still 1 on the pix_tick edge where hcnt wraps to 0 and the new vcnt<V_ACTIVE, then set underrun=1 and clear fetch_req.
REQ-034 If fetch_ack and the deadline occur on the same edge, the ack SHALL win and underrun SHALL NOT be set.
REQ-035 fetch_ack SHALL be ignored while fetch_req=0.
REQ-036 A lock drop mid-line SHALL abandon the pending fetch without setting underrun.
REQ-037 en deasserted mid-frame SHALL let the frame, including its fetches, complete.
REQ-038 All arithmetic SHALL be 11-bit unsigned and counters SHALL never exceed their TOTAL-1.

Reset
REQ-039 While rst=1, asynchronously: state=IDLE, divider=0, hcnt=0, vcnt=0.
REQ-040 While rst=1, outputs SHALL be: hsync=1, vsync=1, de=0, x=0, y=0, pix_tick=0, frame_start=0, fetch_req=0, fetch_line=0, underrun=0, busy=0.
REQ-041 After rst deasserts, the block SHALL stay in IDLE until en=1 and lock=1 are sampled.

Verification
REQ-042 Timing: en=1, lock=1, fetch_ack tied 1 -> pix_tick every 10 clk; hsync low for 960 clk starting at hcnt=656 per 8000-clk line; vsync low for lines 490-491; frame_start period 4,200,000 clk; de high 640 ticks per line on lines 0-479.
REQ-043 Startup: en rises after reset -> fetch_req=1 with fetch_line=0 on the entry edge; first frame_start 160 pixel ticks later.
REQ-044 Underrun: fetch_ack held 0 -> fetch_req set at hcnt=640; underrun=1 on the edge hcnt wraps to 0; fetch_req=0 on that same edge; underrun stays 1 until the next IDLE->RUN.
REQ-045 Race: fetch_ack pulsed on the exact deadline edge -> underrun stays 0 and fetch_req clears.
REQ-046 Stop: en dropped at line 100 -> RUN continues until (799,524), then busy=0; lock dropped at line 100 -> IDLE on the next edge with hsync=1, vsync=1, de=0.
REQ-047 Async reset: rst pulsed mid-line for less than one clock period -> all outputs go to reset values immediately, with no clock edge needed.
